mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port data/instruction memory between two requesters: instruction fetch (I) and load/store (D).
- Sits between the program-counter/fetch path, the load/store path and the memory instance.
- Sequences one transaction at a time: accept, issue, wait a fixed read latency, respond.
- D has priority; a streak limit guarantees that fetch cannot starve.

Parameters:
- ADDR_WIDTH, 32, width of request and memory addresses.
- DATA_WIDTH, 32, width of data words; wstrb width is DATA_WIDTH/8.
- MEM_LATENCY, 1, cycles from the mem_en cycle to mem_rdata being valid; must be >= 1.
- STARVE_LIMIT, 4, maximum consecutive D grants while I is waiting; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  fetch request valid.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  ADDR_WIDTH  fetch address.
- i_resp_valid  out  1  fetch data valid; one-cycle pulse.
- i_resp_data  out  DATA_WIDTH  fetched word.
- d_req_valid  in  1  data request valid.
- d_req_ready  out  1  data request accepted this cycle.
- d_req_addr  in  ADDR_WIDTH  data address.
- d_req_we  in  1  1 = write, 0 = read.
- d_req_wdata  in  DATA_WIDTH  write data.
- d_req_wstrb  in  DATA_WIDTH/8  byte write enables.
- d_resp_valid  out  1  data response; one-cycle pulse (read data or write acknowledge).
- d_resp_data  out  DATA_WIDTH  read word; 0 for writes.
- mem_en  out  1  memory access strobe; one cycle per transaction.
- mem_we  out  1  memory write enable; only ever high together with mem_en.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wstrb  out  DATA_WIDTH/8  memory byte enables.
- mem_rdata  in  DATA_WIDTH  memory read data; valid MEM_LATENCY cycles after the mem_en cycle.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State returns to IDLE; streak counter and latency counter go to 0.
  - All outputs go to 0, including data and address outputs.
  - A transaction in flight is dropped and produces no response.
  - Behaviour resumes on the first rising edge after rst_n is released.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Readies:
  - i_req_ready and d_req_ready are combinational and asserted only in IDLE.
  - At most one ready is high per cycle, and only for a requester with valid=1.
- Arbitration in IDLE:
  - Only one valid: that requester wins.
  - Both valid: D wins unless streak == STARVE_LIMIT, in which case I wins.
- Acceptance at cycle T (valid & ready):
  - Latch owner, addr, we, wdata, wstrb.
  - For an I request, latch we=0 and wstrb=0.
  - Go to ISSUE.
- Streak counter:
  - Increments on a D grant while i_req_valid=1; saturates at STARVE_LIMIT.
  - Clears on any I grant.
  - Clears on a D grant with i_req_valid=0.
- ISSUE (cycle T+1):
  - mem_en=1; mem_addr/mem_wdata/mem_wstrb come from the latched values; mem_we = latched we.
  - Load the latency counter with MEM_LATENCY and go to WAIT.
- mem_* outputs are registered.
  - Outside ISSUE, mem_en=0 and mem_we=0.
  - Outside ISSUE, mem_addr/mem_wdata/mem_wstrb hold their last value.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1 (T+1+MEM_LATENCY), capture mem_rdata (or 0 for a write) and go to RESP.
- RESP (cycle T+2+MEM_LATENCY):
  - The owner's resp_valid=1 for exactly one cycle, with the captured data; the other resp_valid stays 0.
  - Next state is IDLE.
- Response data outputs hold their value until the next response or reset.
- No new request is accepted from ISSUE through RESP.
  - Minimum spacing between acceptances is MEM_LATENCY+3 cycles.
- Requester protocol (not checked): once valid is asserted, valid and request fields stay stable until ready.
- Addresses pass through unmodified; alignment is the requester's responsibility.
- A request deasserted before acceptance is simply not served; there is no internal queue.

Test Plan:
- Reset with i_req_valid=1 held: outputs 0 during reset. First cycle after release: i_req_ready=1. mem_en=1 one cycle later with mem_addr = i_req_addr.
- I read of addr 0x80000000, memory returns 0x00100073 (MEM_LATENCY=1): accept at T, mem_en at T+1, i_resp_valid pulse at T+3 with i_resp_data=0x00100073. d_resp_valid stays 0.
- D write of addr 0x100, wdata 0xDEADBEEF, wstrb 0x3: mem_we=1, mem_wstrb=0x3, mem_wdata=0xDEADBEEF for one cycle. d_resp_valid pulse with d_resp_data=0. A following D read of 0x100 returns 0x0000BEEF from the memory model.
- Both valid continuously, STARVE_LIMIT=4: grant sequence D,D,D,D,I,D,D,D,D,I.
- Reset asserted during WAIT: no resp_valid ever issued for that transaction. After release, the FSM accepts a new request in the first IDLE cycle.
- MEM_LATENCY=3: mem_en at T+1, capture at T+4, resp_valid at T+5. The next ready is no earlier than T+6.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared memory port.
// slave = arbiter view, master = the surrounding fetch/load-store/memory environment.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_resp_valid;
    logic [DATA_WIDTH-1:0] i_resp_data;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic                  d_req_we;
    logic [DATA_WIDTH-1:0] d_req_wdata;
    logic [STRB_WIDTH-1:0] d_req_wstrb;
    logic                  d_resp_valid;
    logic [DATA_WIDTH-1:0] d_resp_data;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_WIDTH-1:0] mem_wstrb;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  i_req_valid, i_req_addr,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        input  mem_rdata,
        output i_req_ready, i_resp_valid, i_resp_data,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output i_req_valid, i_req_addr,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        output mem_rdata,
        input  i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory: one transaction at a time,
// load/store has priority, and a streak counter keeps fetch from starving.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W      = $clog2(MEM_LATENCY + 1);
    localparam int STK_W      = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] LAT_ONE  = CNT_W'(1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_LIMIT);
    localparam logic [STK_W-1:0] STK_ONE  = STK_W'(1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_lat_cnt;
    logic [STK_W-1:0]      r_streak;
    logic                  r_owner_d;
    logic                  r_we;

    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [STRB_WIDTH-1:0] r_mem_wstrb;

    logic                  r_i_resp_valid;
    logic [DATA_WIDTH-1:0] r_i_resp_data;
    logic                  r_d_resp_valid;
    logic [DATA_WIDTH-1:0] r_d_resp_data;

    logic                  w_idle;
    logic                  w_grant_d;
    logic                  w_grant_i;
    logic                  w_accept_d;
    logic                  w_accept_i;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_capture_data;
    logic [STK_W-1:0]      w_streak_inc;
    logic [1:0]            w_state_next;
    logic [CNT_W-1:0]      w_lat_next;
    logic [STK_W-1:0]      w_streak_next;

    // D wins ties unless fetch has already lost STARVE_LIMIT times in a row.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_grant_d  = bus.d_req_valid && (!bus.i_req_valid || (r_streak != STK_MAX));
    assign w_grant_i  = bus.i_req_valid && !w_grant_d;
    assign w_accept_d = w_idle && w_grant_d;
    assign w_accept_i = w_idle && w_grant_i;

    assign w_streak_inc = (r_streak == STK_MAX) ? STK_MAX : (r_streak + STK_ONE);

    assign w_capture      = (r_state == ST_WAIT) && (r_lat_cnt == LAT_ONE);
    assign w_capture_data = r_we ? '0 : bus.mem_rdata;

    // Readies are gated with rst_n so nothing is offered while reset is held.
    assign bus.i_req_ready = rst_n && w_accept_i;
    assign bus.d_req_ready = rst_n && w_accept_d;

    always_comb begin
        w_state_next  = r_state;
        w_lat_next    = r_lat_cnt;
        w_streak_next = r_streak;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_next  = ST_ISSUE;
                    w_streak_next = bus.i_req_valid ? w_streak_inc : '0;
                end else if (w_grant_i) begin
                    w_state_next  = ST_ISSUE;
                    w_streak_next = '0;
                end
            end
            ST_ISSUE: begin
                w_lat_next   = LAT_LOAD;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_lat_next = r_lat_cnt - LAT_ONE;
                if (r_lat_cnt == LAT_ONE) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lat_cnt <= '0;
            r_streak  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_lat_cnt <= w_lat_next;
            r_streak  <= w_streak_next;
        end
    end

    // mem_* is loaded on the accepting edge so the strobe lands in the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_d      <= 1'b0;
            r_we           <= 1'b0;
            r_mem_en       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_wstrb    <= '0;
            r_i_resp_valid <= 1'b0;
            r_i_resp_data  <= '0;
            r_d_resp_valid <= 1'b0;
            r_d_resp_data  <= '0;
        end else begin
            r_mem_en <= w_accept_d || w_accept_i;
            r_mem_we <= w_accept_d && bus.d_req_we;

            if (w_accept_d) begin
                r_owner_d   <= 1'b1;
                r_we        <= bus.d_req_we;
                r_mem_addr  <= bus.d_req_addr;
                r_mem_wdata <= bus.d_req_wdata;
                r_mem_wstrb <= bus.d_req_wstrb;
            end else if (w_accept_i) begin
                r_owner_d   <= 1'b0;
                r_we        <= 1'b0;
                r_mem_addr  <= bus.i_req_addr;
                r_mem_wstrb <= '0;
            end

            r_i_resp_valid <= w_capture && !r_owner_d;
            r_d_resp_valid <= w_capture && r_owner_d;
            if (w_capture) begin
                if (r_owner_d) begin
                    r_d_resp_data <= w_capture_data;
                end else begin
                    r_i_resp_data <= w_capture_data;
                end
            end
        end
    end

    assign bus.mem_en       = r_mem_en;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.mem_wstrb    = r_mem_wstrb;
    assign bus.i_resp_valid = r_i_resp_valid;
    assign bus.i_resp_data  = r_i_resp_data;
    assign bus.d_resp_valid = r_d_resp_valid;
    assign bus.d_resp_data  = r_d_resp_data;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiter instances (latency 1 and latency 3) each with a
// small memory model; inputs change 1 ns after the rising edge, outputs checked there too.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    // Memory models: read data is valid only in the cycle MEM_LATENCY after mem_en.
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] rd1;
    logic [31:0] p0, p1, p2;

    always @(posedge clk) begin
        if (pl_en) begin
            mem1[pl_idx] <= pl_data;
        end else if (bus1.mem_en && bus1.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus1.mem_wstrb[b]) mem1[bus1.mem_addr[9:2]][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
        end
        rd1 <= (bus1.mem_en && !bus1.mem_we) ? mem1[bus1.mem_addr[9:2]] : 32'h5A5A_5A5A;
    end
    assign bus1.mem_rdata = rd1;

    always @(posedge clk) begin
        if (pl_en) begin
            mem3[pl_idx] <= pl_data;
        end else if (bus3.mem_en && bus3.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus3.mem_wstrb[b]) mem3[bus3.mem_addr[9:2]][8*b +: 8] <= bus3.mem_wdata[8*b +: 8];
        end
        p0 <= (bus3.mem_en && !bus3.mem_we) ? mem3[bus3.mem_addr[9:2]] : 32'h5A5A_5A5A;
        p1 <= p0;
        p2 <= p1;
    end
    assign bus3.mem_rdata = p2;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete D transaction on the latency-1 instance, starting in IDLE.
    task automatic d_txn1(input string tag, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] exp_data);
        bus1.d_req_valid = 1'b1;
        bus1.d_req_addr  = addr;
        bus1.d_req_we    = we;
        bus1.d_req_wdata = wdata;
        bus1.d_req_wstrb = wstrb;
        #1;
        chk({tag, "_d_ready"}, {31'b0, bus1.d_req_ready}, 32'd1);
        chk({tag, "_i_ready"}, {31'b0, bus1.i_req_ready}, 32'd0);
        step();
        bus1.d_req_valid = 1'b0;
        chk({tag, "_mem_en"}, {31'b0, bus1.mem_en}, 32'd1);
        chk({tag, "_mem_we"}, {31'b0, bus1.mem_we}, {31'b0, we});
        chk({tag, "_mem_addr"}, bus1.mem_addr, addr);
        chk({tag, "_mem_wdata"}, bus1.mem_wdata, wdata);
        chk({tag, "_mem_wstrb"}, {28'b0, bus1.mem_wstrb}, {28'b0, wstrb});
        step();
        chk({tag, "_mem_en_off"}, {31'b0, bus1.mem_en}, 32'd0);
        chk({tag, "_mem_we_off"}, {31'b0, bus1.mem_we}, 32'd0);
        chk({tag, "_resp_early"}, {31'b0, bus1.d_resp_valid}, 32'd0);
        step();
        chk({tag, "_d_resp_valid"}, {31'b0, bus1.d_resp_valid}, 32'd1);
        chk({tag, "_d_resp_data"}, bus1.d_resp_data, exp_data);
        chk({tag, "_i_resp_quiet"}, {31'b0, bus1.i_resp_valid}, 32'd0);
        $display("txn %s: addr=%h we=%0d wdata=%h wstrb=%h resp=%h", tag, addr, we, wdata, wstrb, bus1.d_resp_data);
        step();
        chk({tag, "_d_resp_pulse"}, {31'b0, bus1.d_resp_valid}, 32'd0);
    endtask

    logic [9:0] exp_pat;

    initial begin
        bus1.i_req_valid = 1'b1;
        bus1.i_req_addr  = 32'h8000_0000;
        bus1.d_req_valid = 1'b0;
        bus1.d_req_addr  = '0;
        bus1.d_req_we    = 1'b0;
        bus1.d_req_wdata = '0;
        bus1.d_req_wstrb = '0;
        bus3.i_req_valid = 1'b0;
        bus3.i_req_addr  = '0;
        bus3.d_req_valid = 1'b0;
        bus3.d_req_addr  = '0;
        bus3.d_req_we    = 1'b0;
        bus3.d_req_wdata = '0;
        bus3.d_req_wstrb = '0;
        pl_en   = 1'b1;
        pl_idx  = 8'h00;
        pl_data = 32'h0010_0073;
        step();
        pl_idx  = 8'h40;
        pl_data = 32'h0000_0000;
        step();
        pl_idx  = 8'h02;
        pl_data = 32'h1234_5678;
        step();
        pl_en = 1'b0;

        // Held in reset with a fetch request pending.
        chk("rst_i_ready", {31'b0, bus1.i_req_ready}, 32'd0);
        chk("rst_d_ready", {31'b0, bus1.d_req_ready}, 32'd0);
        chk("rst_mem_en", {31'b0, bus1.mem_en}, 32'd0);
        chk("rst_mem_addr", bus1.mem_addr, 32'd0);
        chk("rst_i_resp_valid", {31'b0, bus1.i_resp_valid}, 32'd0);
        chk("rst_i_resp_data", bus1.i_resp_data, 32'd0);
        chk("rst_d_resp_data", bus1.d_resp_data, 32'd0);

        rst_n = 1'b1;
        #1;
        chk("ifetch_i_ready", {31'b0, bus1.i_req_ready}, 32'd1);
        chk("ifetch_d_ready", {31'b0, bus1.d_req_ready}, 32'd0);
        step();
        bus1.i_req_valid = 1'b0;
        chk("ifetch_mem_en", {31'b0, bus1.mem_en}, 32'd1);
        chk("ifetch_mem_we", {31'b0, bus1.mem_we}, 32'd0);
        chk("ifetch_mem_addr", bus1.mem_addr, 32'h8000_0000);
        chk("ifetch_mem_wstrb", {28'b0, bus1.mem_wstrb}, 32'd0);
        chk("ifetch_no_ready", {31'b0, bus1.i_req_ready}, 32'd0);
        step();
        chk("ifetch_mem_en_off", {31'b0, bus1.mem_en}, 32'd0);
        chk("ifetch_resp_early", {31'b0, bus1.i_resp_valid}, 32'd0);
        step();
        chk("ifetch_i_resp_valid", {31'b0, bus1.i_resp_valid}, 32'd1);
        chk("ifetch_i_resp_data", bus1.i_resp_data, 32'h0010_0073);
        chk("ifetch_d_resp_quiet", {31'b0, bus1.d_resp_valid}, 32'd0);
        $display("txn ifetch: addr=80000000 resp=%h", bus1.i_resp_data);
        step();
        chk("ifetch_resp_pulse", {31'b0, bus1.i_resp_valid}, 32'd0);
        chk("ifetch_resp_hold", bus1.i_resp_data, 32'h0010_0073);

        d_txn1("dwr", 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'h0000_0000);
        d_txn1("drd", 32'h0000_0100, 1'b0, 32'h0000_0000, 4'h0, 32'h0000_BEEF);

        // Both requesters valid continuously: expect D,D,D,D,I,D,D,D,D,I (bit set = I).
        exp_pat = 10'b10_0001_0000;
        bus1.i_req_valid = 1'b1;
        bus1.i_req_addr  = 32'h8000_0000;
        bus1.d_req_valid = 1'b1;
        bus1.d_req_addr  = 32'h0000_0100;
        bus1.d_req_we    = 1'b0;
        bus1.d_req_wstrb = 4'h0;
        #1;
        for (int g = 0; g < 10; g++) begin
            int waited;
            waited = 0;
            while (!(bus1.i_req_ready || bus1.d_req_ready) && waited < 8) begin
                step();
                waited++;
            end
            chk($sformatf("grant%0d_seen", g), {31'b0, bus1.i_req_ready | bus1.d_req_ready}, 32'd1);
            chk($sformatf("grant%0d_i", g), {31'b0, bus1.i_req_ready}, {31'b0, exp_pat[g]});
            chk($sformatf("grant%0d_d", g), {31'b0, bus1.d_req_ready}, {31'b0, ~exp_pat[g]});
            $display("txn grant%0d: %s", g, bus1.i_req_ready ? "I" : "D");
            step();
        end
        bus1.i_req_valid = 1'b0;
        bus1.d_req_valid = 1'b0;
        step();
        step();
        step();

        // Reset while a D read sits in WAIT: that read must never respond.
        bus1.d_req_valid = 1'b1;
        bus1.d_req_addr  = 32'h0000_0100;
        bus1.d_req_we    = 1'b0;
        #1;
        chk("rstwait_d_ready", {31'b0, bus1.d_req_ready}, 32'd1);
        step();
        bus1.d_req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rstwait_mem_en", {31'b0, bus1.mem_en}, 32'd0);
        chk("rstwait_d_resp_data", bus1.d_resp_data, 32'd0);
        chk("rstwait_i_resp_data", bus1.i_resp_data, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("rstwait_quiet%0d", k), {31'b0, bus1.d_resp_valid}, 32'd0);
        end
        bus1.i_req_valid = 1'b1;
        bus1.i_req_addr  = 32'h8000_0000;
        rst_n = 1'b1;
        #1;
        chk("rstwait_i_ready", {31'b0, bus1.i_req_ready}, 32'd1);
        step();
        bus1.i_req_valid = 1'b0;
        chk("rstwait_mem_en_new", {31'b0, bus1.mem_en}, 32'd1);
        chk("rstwait_d_quiet_a", {31'b0, bus1.d_resp_valid}, 32'd0);
        step();
        chk("rstwait_d_quiet_b", {31'b0, bus1.d_resp_valid}, 32'd0);
        chk("rstwait_i_quiet", {31'b0, bus1.i_resp_valid}, 32'd0);
        step();
        chk("rstwait_i_resp_valid", {31'b0, bus1.i_resp_valid}, 32'd1);
        chk("rstwait_i_resp_data", bus1.i_resp_data, 32'h0010_0073);
        chk("rstwait_d_quiet_c", {31'b0, bus1.d_resp_valid}, 32'd0);
        $display("txn refetch after reset: resp=%h", bus1.i_resp_data);
        step();

        // Latency-3 instance: mem_en at T+1, response at T+5, next ready at T+6.
        bus3.d_req_valid = 1'b1;
        bus3.d_req_addr  = 32'h0000_0008;
        bus3.d_req_we    = 1'b0;
        #1;
        chk("lat3_d_ready", {31'b0, bus3.d_req_ready}, 32'd1);
        step();
        bus3.d_req_valid = 1'b0;
        chk("lat3_mem_en", {31'b0, bus3.mem_en}, 32'd1);
        chk("lat3_mem_addr", bus3.mem_addr, 32'h0000_0008);
        step();
        chk("lat3_mem_en_off", {31'b0, bus3.mem_en}, 32'd0);
        step();
        chk("lat3_resp_t3", {31'b0, bus3.d_resp_valid}, 32'd0);
        step();
        chk("lat3_resp_t4", {31'b0, bus3.d_resp_valid}, 32'd0);
        step();
        chk("lat3_resp_t5", {31'b0, bus3.d_resp_valid}, 32'd1);
        chk("lat3_resp_data", bus3.d_resp_data, 32'h1234_5678);
        $display("txn lat3 read: addr=00000008 resp=%h", bus3.d_resp_data);
        bus3.d_req_valid = 1'b1;
        #1;
        chk("lat3_no_ready_t5", {31'b0, bus3.d_req_ready}, 32'd0);
        step();
        chk("lat3_resp_pulse", {31'b0, bus3.d_resp_valid}, 32'd0);
        chk("lat3_ready_t6", {31'b0, bus3.d_req_ready}, 32'd1);
        step();
        bus3.d_req_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end
endmodule
